// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: halt opcode, default
// geometry, queue-entry layout and the fetch control states.
package fetch_pkg;

    localparam logic [5:0] OPC_HALT     = 6'b111111;
    localparam int         PC_W_DEF     = 8;
    localparam int         RESET_PC_DEF = 11;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_W_DEF-1:0] pc;
    } fetch_entry_t;

    // BOOT idles the first cycle after reset so requests never start while rst is high.
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HALTED
    } fetch_state_t;

    function automatic logic is_halt(input logic [5:0] opcode);
        return opcode == OPC_HALT;
    endfunction

endpackage

// File: rtl/pc_sync_fifo.sv
// Small circular prefetch buffer with synchronous flush. The head entry is held
// in a register so the consumer sees a stable, glitch-free word and PC.
module pc_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next, remain;
    logic [W-1:0]     head_reg, head_next;
    logic             pop_eff;

    always_comb begin
        pop_eff     = pop && (count_reg != '0);
        remain      = count_reg - CNT_W'(pop_eff);
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        head_next   = head_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
            head_next   = '0;
        end else begin
            if (pop_eff) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            if (push)    wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            count_next = remain + CNT_W'(push);
            // A word pushed into an emptying queue bypasses the array straight to the head.
            if (count_next == '0)
                head_next = '0;
            else if (remain == '0)
                head_next = push_data;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign head_data = head_reg;
    assign count     = count_reg;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the PC, issues single-outstanding reads to a 1-cycle
// instruction memory and queues the returned words for decode.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [31:0]     inst_out,
    output logic [PC_W-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            halted
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 32 + PC_W;

    fetch_state_t    state_reg, state_next;
    logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PC_W-1:0] inflight_pc_reg;
    logic            epoch_reg, inflight_reg, inflight_epoch_reg;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]  occupancy;
    logic [ENT_W-1:0] head_data;
    logic            resp_push, resp_halt, issue;

    // A response that lands during a redirect belongs to the old stream.
    assign resp_push = inflight_reg && (inflight_epoch_reg == epoch_reg) && !redirect_valid;
    assign resp_halt = resp_push && is_halt(imem_rdata[31:26]);
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
    // Counting the in-flight word keeps a free slot for every outstanding response.
    assign issue = (state_reg == ST_FETCH) && !redirect_valid && !resp_halt
                && (occupancy < (CNT_W + 1)'(DEPTH));

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid) begin
            state_next    = ST_FETCH;
            fetch_pc_next = redirect_pc;
        end else begin
            case (state_reg)
                ST_BOOT:  state_next = ST_FETCH;
                ST_FETCH: if (resp_halt) state_next = ST_HALTED;
                default:  state_next = state_reg;
            endcase
            if (issue) fetch_pc_next = fetch_pc_reg + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_BOOT;
            fetch_pc_reg       <= PC_W'(RESET_PC);
            epoch_reg          <= 1'b0;
            inflight_reg       <= 1'b0;
            inflight_pc_reg    <= '0;
            inflight_epoch_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            epoch_reg    <= epoch_reg ^ redirect_valid;
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg    <= fetch_pc_reg;
                inflight_epoch_reg <= epoch_reg;
            end
        end
    end

    pc_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (resp_push),
        .push_data ({imem_rdata, inflight_pc_reg}),
        .pop       (inst_ready),
        .head_data (head_data),
        .count     (fifo_count)
    );

    assign imem_req   = issue;
    assign imem_addr  = issue ? fetch_pc_reg : '0;
    assign inst_valid = (fifo_count != '0);
    assign inst_out   = head_data[ENT_W-1:PC_W];
    assign inst_pc    = head_data[PC_W-1:0];
    assign halted     = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised and directed bench for inst_fetch_queue against a queue-level
// model of the fetch stream (request order, in-order delivery, flush, halt).
module tb_inst_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_req2;
    logic [7:0]  imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        redirect_valid, redirect_valid2;
    logic [7:0]  redirect_pc, redirect_pc2;
    logic        inst_valid, inst_valid2;
    logic [31:0] inst_out, inst_out2;
    logic [7:0]  inst_pc, inst_pc2;
    logic        inst_ready, inst_ready2;
    logic        halted, halted2;

    always #5 clk = ~clk;

    inst_fetch_queue #(.PC_W(8), .DEPTH(DEPTH), .RESET_PC(11)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .halted(halted)
    );

    inst_fetch_queue #(.PC_W(8), .DEPTH(DEPTH), .RESET_PC(254)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .inst_valid(inst_valid2), .inst_out(inst_out2), .inst_pc(inst_pc2),
        .inst_ready(inst_ready2), .halted(halted2)
    );

    // Instruction memory with one cycle of read latency.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? mem[imem_addr]  : 32'h0;
        imem_rdata2 <= imem_req2 ? mem[imem_addr2] : 32'h0;
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: expected delivery queue, one pending read, next fetch PC.
    fetch_entry_t m_q[$];
    bit m_started, m_halted, m_pend_v;
    int m_fetch_pc, m_pend_pc;
    int n_req, n_hs;
    int req_log[$];
    int hs_log[$];
    bit obs_req, obs_valid;

    function automatic logic [31:0] default_word(input int k);
        return 32'h2000_0000 | 32'(k);
    endfunction

    task automatic fill_mem();
        for (int k = 0; k < 256; k++) mem[k] = default_word(k);
    endtask

    task automatic model_reset(input int pc);
        m_q.delete();
        m_started = 0;
        m_halted  = 0;
        m_pend_v  = 0;
        m_fetch_pc = pc;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset(11);
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle_step(input logic ready, input logic redir, input logic [7:0] rpc);
        bit exp_req, hs, halt_arriving;
        inst_ready = ready;
        redirect_valid = redir;
        redirect_pc = rpc;
        #1;
        halt_arriving = m_pend_v && (mem[m_pend_pc][31:26] == OPC_HALT);
        exp_req = m_started && !m_halted && !redir && !halt_arriving
               && ((m_q.size() + (m_pend_v ? 1 : 0)) < DEPTH);
        vectors++;
        if (imem_req !== exp_req) begin
            miscompares++;
            $display("FAIL imem_req: got %b expected %b (t=%0t)", imem_req, exp_req, $time);
        end
        if (exp_req) begin
            vectors++;
            if (imem_addr !== 8'(m_fetch_pc)) begin
                miscompares++;
                $display("FAIL imem_addr: got %0d expected %0d", imem_addr, m_fetch_pc);
            end
        end
        vectors++;
        if (inst_valid !== (m_q.size() != 0)) begin
            miscompares++;
            $display("FAIL inst_valid: got %b expected %b (t=%0t)", inst_valid, m_q.size() != 0, $time);
        end
        if (m_q.size() != 0) begin
            vectors++;
            if (inst_pc !== m_q[0].pc || inst_out !== m_q[0].instr) begin
                miscompares++;
                $display("FAIL head: got pc=%0d word=%h expected pc=%0d word=%h",
                         inst_pc, inst_out, m_q[0].pc, m_q[0].instr);
            end
        end
        vectors++;
        if (halted !== m_halted) begin
            miscompares++;
            $display("FAIL halted: got %b expected %b", halted, m_halted);
        end
        obs_req = (imem_req === 1'b1);
        obs_valid = (inst_valid === 1'b1);
        if (obs_req) begin n_req++; req_log.push_back(int'(imem_addr)); end
        if (obs_valid && ready) begin n_hs++; hs_log.push_back(int'(inst_pc)); end

        hs = ready && (m_q.size() != 0);
        if (redir) begin
            m_q.delete();
            m_pend_v = 0;
            m_fetch_pc = int'(rpc);
            m_halted = 0;
        end else begin
            if (hs) void'(m_q.pop_front());
            if (m_pend_v) begin
                m_q.push_back('{instr: mem[m_pend_pc], pc: 8'(m_pend_pc)});
                if (mem[m_pend_pc][31:26] == OPC_HALT) m_halted = 1;
            end
            m_pend_v = exp_req;
            m_pend_pc = m_fetch_pc;
            if (exp_req) m_fetch_pc = (m_fetch_pc + 1) % 256;
        end
        m_started = 1;
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        n_req = 0; n_hs = 0;
        req_log.delete(); hs_log.delete();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'd0;
        #2;
        vectors++;
        if ({inst_valid, imem_req, halted} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got valid/req/halted=%b expected 000", {inst_valid, imem_req, halted});
        end
        vectors++;
        if (inst_out !== 32'h0 || inst_pc !== 8'h0 || imem_addr !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_data: got out=%h pc=%0d addr=%0d expected 0", inst_out, inst_pc, imem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset(11);
    endtask

    task automatic test_stream();
        int first_req = -1, first_valid = -1;
        apply_reset(); clear_logs();
        for (int i = 0; i < 20; i++) begin
            cycle_step(1'b1, 1'b0, 8'd0);
            if (obs_req && first_req < 0) first_req = i;
            if (obs_valid && first_valid < 0) first_valid = i;
        end
        vectors++;
        if (first_valid - first_req != 2) begin
            miscompares++;
            $display("FAIL stream_latency: got %0d cycles expected 2", first_valid - first_req);
        end
        vectors++;
        if (n_hs != 17) begin
            miscompares++;
            $display("FAIL stream_throughput: got %0d transfers expected 17", n_hs);
        end
    endtask

    task automatic test_backpressure();
        apply_reset(); clear_logs();
        for (int i = 0; i < 10; i++) cycle_step(1'b0, 1'b0, 8'd0);
        vectors++;
        if (n_req != 4 || req_log[0] != 11 || req_log[3] != 14) begin
            miscompares++;
            $display("FAIL bp_requests: got %0d requests expected 4 at 11..14", n_req);
        end
        vectors++;
        if (inst_out !== default_word(11)) begin
            miscompares++;
            $display("FAIL bp_hold: got %h expected %h", inst_out, default_word(11));
        end
        clear_logs();
        for (int i = 0; i < 5; i++) cycle_step(1'b1, 1'b0, 8'd0);
        vectors++;
        if (n_hs != 5 || hs_log[0] != 11 || hs_log[4] != 15) begin
            miscompares++;
            $display("FAIL bp_release: got %0d transfers expected 5 (11..15)", n_hs);
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        for (int i = 0; i < 5; i++) cycle_step(1'b0, 1'b0, 8'd0);
        cycle_step(1'b0, 1'b1, 8'd40);
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_flush: got valid=%b expected 0", inst_valid);
        end
        clear_logs();
        for (int i = 0; i < 6; i++) cycle_step(1'b1, 1'b0, 8'd0);
        vectors++;
        if (req_log.size() == 0 || req_log[0] != 40 || hs_log.size() == 0 || hs_log[0] != 40) begin
            miscompares++;
            $display("FAIL redir_target: got first req/pc %0d/%0d expected 40/40",
                     req_log.size() ? req_log[0] : -1, hs_log.size() ? hs_log[0] : -1);
        end
    endtask

    task automatic test_halt();
        int n14 = 0;
        mem[13] = 32'hFC00_0000;
        apply_reset(); clear_logs();
        for (int i = 0; i < 14; i++) cycle_step(1'b1, 1'b0, 8'd0);
        foreach (req_log[k]) if (req_log[k] == 14) n14++;
        vectors++;
        if (halted !== 1'b1 || n14 != 0) begin
            miscompares++;
            $display("FAIL halt_stop: got halted=%b reqs_to_14=%0d expected 1/0", halted, n14);
        end
        vectors++;
        if (hs_log.size() == 0 || hs_log[hs_log.size()-1] != 13) begin
            miscompares++;
            $display("FAIL halt_deliver: got last pc %0d expected 13",
                     hs_log.size() ? hs_log[hs_log.size()-1] : -1);
        end
        cycle_step(1'b1, 1'b1, 8'd20);
        vectors++;
        if (halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_clear: got %b expected 0", halted);
        end
        clear_logs();
        for (int i = 0; i < 4; i++) cycle_step(1'b1, 1'b0, 8'd0);
        vectors++;
        if (req_log.size() == 0 || req_log[0] != 20) begin
            miscompares++;
            $display("FAIL halt_resume: got %0d expected 20", req_log.size() ? req_log[0] : -1);
        end
        mem[13] = default_word(13);
    endtask

    task automatic test_wrap();
        int exp_a = 254, exp_p = 254, na = 0, np = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req2 === 1'b1) begin
                vectors++;
                if (imem_addr2 !== 8'(exp_a)) begin
                    miscompares++;
                    $display("FAIL wrap_addr: got %0d expected %0d", imem_addr2, exp_a);
                end
                exp_a = (exp_a + 1) % 256; na++;
            end
            if (inst_valid2 === 1'b1) begin
                vectors++;
                if (inst_pc2 !== 8'(exp_p) || inst_out2 !== default_word(exp_p)) begin
                    miscompares++;
                    $display("FAIL wrap_pc: got %0d/%h expected %0d/%h", inst_pc2, inst_out2, exp_p, default_word(exp_p));
                end
                exp_p = (exp_p + 1) % 256; np++;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (na < 4 || np < 4) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d reqs %0d insts expected >=4 each", na, np);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) cycle_step(1'b0, 1'b0, 8'd0);
        vectors++;
        if (inst_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL async_pre: got valid=%b expected 1", inst_valid);
        end
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL async_clear: got valid=%b req=%b expected 0/0", inst_valid, imem_req);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset(11);
        clear_logs();
        for (int i = 0; i < 6; i++) cycle_step(1'b1, 1'b0, 8'd0);
        vectors++;
        if (req_log.size() == 0 || req_log[0] != 11) begin
            miscompares++;
            $display("FAIL async_restart: got %0d expected 11", req_log.size() ? req_log[0] : -1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 256; k++)
            if ($urandom_range(0, 19) == 0) mem[k] = 32'hFC00_0000 | 32'(k);
        apply_reset();
        for (int i = 0; i < 400; i++)
            cycle_step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom_range(0, 255)));
        fill_mem();
    endtask

    initial begin
        inst_ready2 = 1'b1;
        redirect_valid2 = 1'b0;
        redirect_pc2 = 8'd0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'd0;
        fill_mem();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
